mux2to1: RTL and testbench
==========================

Name: mux2to1

Overview:
- 2-to-1 selector: OUT = A when SEL=0, B when SEL=1.
- The OUT path is purely combinational and has zero latency.
- A registered copy of OUT is provided for pipelined consumers, along with a valid flag and a saturating counter of SEL transitions for debug and observability.
- Sits as a leaf datapath primitive; WIDTH=1 is the bit-level mux.

Parameters:
- WIDTH, 1, data width of A, B, OUT, OUT_Q.
- CNT_W, 8, width of the SEL-toggle counter.
- RESET_OUT, 0, value loaded into OUT_Q on reset (WIDTH bits, zero-extended).

Ports:
- clk  in  1  single clock; all registered state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- A  in  WIDTH  data input 0.
- B  in  WIDTH  data input 1.
- SEL  in  1  select: 0 chooses A, 1 chooses B.
- EN  in  1  capture enable for the registered path.
- OUT  out  WIDTH  combinational mux result.
- OUT_Q  out  WIDTH  registered mux result.
- OUT_VLD  out  1  high for one cycle after a capture.
- SEL_TOG_CNT  out  CNT_W  saturating count of SEL value changes.

Behaviour:
- Combinational path:
  - OUT = SEL ? B : A at all times, including during reset.
  - No clock dependency; OUT settles within the same delta as the input change.
  - SEL=X/Z: OUT = X in simulation. No synthesis requirement beyond the 2:1 function.
- Registered path, on a rising clk edge:
  - rst_n=0: OUT_Q <= RESET_OUT, OUT_VLD <= 0, SEL_TOG_CNT <= 0, sel_prev <= 0.
  - Otherwise, if EN=1: OUT_Q <= OUT (value sampled at the edge) and OUT_VLD <= 1.
  - Otherwise (EN=0): OUT_Q holds and OUT_VLD <= 0.
  - Latency OUT -> OUT_Q is 1 cycle.
  - No backpressure; OUT_VLD is a pure qualifier.
- Toggle counter:
  - sel_prev <= SEL every non-reset edge.
  - If SEL != sel_prev and SEL_TOG_CNT != all-ones, increment by 1.
  - Saturates at 2^CNT_W-1 and holds until reset.
- Reset mid-operation:
  - Reset overrides EN and the counter in the same edge.
  - OUT is unaffected by reset.
- Simultaneous SEL change and EN on the same edge: OUT_Q captures the new-SEL result, and the counter increments in the same cycle.
- The first edge after reset release with SEL=1 counts as a toggle, because sel_prev resets to 0.
- Never infer latches; all registers reset.

Decomposition:
- Shared package: none required. WIDTH/CNT_W are local parameters.
- One natural sub-module: sat_counter (CNT_W-wide saturating incrementer with sync active-low clear), used for SEL_TOG_CNT.
- The mux itself stays inline.

Test Plan:
- Combinational sweep, WIDTH=1, no clock needed, 1 ns steps. Expected OUT: 0, 1, 1, 1, 1.
  - A=0 B=0 SEL=0 -> OUT=0
  - A=0 B=1 SEL=1 -> OUT=1
  - A=1 B=0 SEL=0 -> OUT=1
  - A=1 B=0 SEL=0 -> OUT=1 (repeat)
  - A=0 B=1 SEL=1 -> OUT=1
- Exhaustive 1-bit: all 8 {A,B,SEL} combinations -> OUT equals the truth table. Check at 1 ns after each change.
- Reset:
  - Hold rst_n=0 for 2 edges with EN=1, SEL toggling -> OUT_Q=RESET_OUT, OUT_VLD=0, SEL_TOG_CNT=0.
  - OUT still tracks the inputs throughout.
- Registered capture, WIDTH=8:
  - A=0x5A, B=0xA5, SEL=0, EN=1 -> OUT_Q=0x5A and OUT_VLD=1 after 1 edge.
  - SEL=1 -> OUT_Q=0xA5 on the next edge.
  - EN=0 -> OUT_Q holds 0xA5 and OUT_VLD=0.
- Counter saturation, CNT_W=2: toggle SEL every cycle for 5 cycles -> counter reads 1, 2, 3, 3, 3.
- Reset mid-run: assert rst_n=0 while EN=1 and the counter is 2 -> next edge OUT_Q=RESET_OUT, counter=0, OUT_VLD=0.

Source files
------------

// File: rtl/mux2to1_pkg.sv
// Shared defaults and small helpers for the mux2to1 slice.
package mux2to1_pkg;

    // Default geometry: bit-level mux with an 8-bit toggle counter.
    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 8;

    // A select change is any difference between the current and previous select.
    function automatic logic sel_toggled(input logic sel, input logic sel_prev);
        return sel ^ sel_prev;
    endfunction

endpackage

// File: rtl/mux2to1_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Once the count reaches all-ones it holds there until cleared.
module mux2to1_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Increment on request unless already saturated; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux2to1.sv
// 2-to-1 selector with a zero-latency combinational output, a registered
// copy of the result, a capture qualifier and a saturating count of
// select changes for debug visibility.
//
// Handshake: there is no backpressure. OUT_VLD is a pure qualifier that is
// high for exactly the cycle following an edge where EN was sampled high;
// OUT_Q holds its value whenever OUT_VLD is low.
module mux2to1
    import mux2to1_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               CNT_W     = DEFAULT_CNT_W,
    parameter logic [WIDTH-1:0] RESET_OUT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SEL,
    input  logic             EN,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] OUT_Q,
    output logic             OUT_VLD,
    output logic [CNT_W-1:0] SEL_TOG_CNT
);

    logic sel_prev;
    logic sel_changed;

    // Combinational select; independent of clock and reset.
    always_comb begin
        OUT = SEL ? B : A;
    end

    // Registered copy of the mux result plus its one-cycle qualifier.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            OUT_Q   <= RESET_OUT;
            OUT_VLD <= 1'b0;
        end else if (EN) begin
            OUT_Q   <= OUT;
            OUT_VLD <= 1'b1;
        end else begin
            OUT_VLD <= 1'b0;
        end
    end

    // Previous select value; resets to 0 so a first edge with SEL=1 counts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_prev <= 1'b0;
        end else begin
            sel_prev <= SEL;
        end
    end

    assign sel_changed = sel_toggled(SEL, sel_prev);

    mux2to1_sat_counter #(
        .CNT_W (CNT_W)
    ) u_tog_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sel_changed),
        .cnt   (SEL_TOG_CNT)
    );

endmodule

// File: tb/tb_mux2to1.sv
// Testbench for mux2to1: a 1-bit instance for the combinational truth table
// and an 8-bit instance with a 2-bit counter for the registered path.
module tb_mux2to1;

  localparam int         W        = 8;
  localparam int         CW       = 2;
  localparam logic [7:0] RST_VAL  = 8'h3C;
  localparam int         CNT_MAX  = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-bit instance signals
  logic       b_rst_n, b_a, b_b, b_sel, b_en;
  logic       b_out, b_out_q, b_vld;
  logic [7:0] b_cnt;

  // 8-bit instance signals
  logic          rst_n, sel, en;
  logic [W-1:0]  a, b;
  logic [W-1:0]  out, out_q;
  logic          out_vld;
  logic [CW-1:0] cnt;

  mux2to1 #(.WIDTH(1), .CNT_W(8), .RESET_OUT(1'b0)) u_bit (
    .clk(clk), .rst_n(b_rst_n), .A(b_a), .B(b_b), .SEL(b_sel), .EN(b_en),
    .OUT(b_out), .OUT_Q(b_out_q), .OUT_VLD(b_vld), .SEL_TOG_CNT(b_cnt)
  );

  mux2to1 #(.WIDTH(W), .CNT_W(CW), .RESET_OUT(RST_VAL)) u_dut (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .SEL(sel), .EN(en),
    .OUT(out), .OUT_Q(out_q), .OUT_VLD(out_vld), .SEL_TOG_CNT(cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  logic [W-1:0] m_q;
  logic         m_vld;
  int           m_cnt;
  logic         m_prev;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] pick(input logic s, input logic [W-1:0] x0,
                                         input logic [W-1:0] x1);
    if (s) return x1;
    return x0;
  endfunction

  // Advance the model by one rising edge using the inputs held at that edge.
  task automatic model_edge(input logic r, input logic e, input logic s,
                            input logic [W-1:0] x0, input logic [W-1:0] x1);
    if (!r) begin
      m_q = RST_VAL; m_vld = 1'b0; m_cnt = 0; m_prev = 1'b0;
      exp_q.delete();
    end else begin
      if (e) begin
        m_q = pick(s, x0, x1);
        exp_q.push_back(m_q);
      end
      m_vld = e;
      if (s != m_prev) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      m_prev = s;
    end
  endtask

  // ---------------- driver ----------------
  // One clock: snapshot inputs, wait for the edge, update model, settle.
  task automatic step();
    logic r, e, s;
    logic [W-1:0] x0, x1;
    r = rst_n; e = en; s = sel; x0 = a; x1 = b;
    @(posedge clk);
    model_edge(r, e, s, x0, x1);
    #1;
  endtask

  task automatic check_regs(input string name);
    n_checks++;
    if (out_q !== m_q) begin
      n_errors++;
      $display("FAIL %s out_q: got %h expected %h", name, out_q, m_q);
    end
    n_checks++;
    if (out_vld !== m_vld) begin
      n_errors++;
      $display("FAIL %s out_vld: got %b expected %b", name, out_vld, m_vld);
    end
    n_checks++;
    if (cnt !== m_cnt[CW-1:0]) begin
      n_errors++;
      $display("FAIL %s cnt: got %0d expected %0d", name, cnt, m_cnt);
    end
  endtask

  task automatic check_comb(input string name);
    n_checks++;
    if (out !== pick(sel, a, b)) begin
      n_errors++;
      $display("FAIL %s out: got %h expected %h", name, out, pick(sel, a, b));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_comb_sweep();
    logic [2:0] vec [5];
    logic       exp [5];
    vec = '{3'b000, 3'b011, 3'b100, 3'b100, 3'b011};
    exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      {b_a, b_b, b_sel} = vec[i];
      #1;
      n_checks++;
      if (b_out !== exp[i]) begin
        n_errors++;
        $display("FAIL comb_sweep[%0d]: got %b expected %b", i, b_out, exp[i]);
      end
    end
  endtask

  task automatic test_comb_exhaustive();
    logic [2:0] v;
    logic       e;
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      {b_a, b_b, b_sel} = v;
      e = v[0] ? v[1] : v[2];
      #1;
      n_checks++;
      if (b_out !== e) begin
        n_errors++;
        $display("FAIL comb_exhaustive abs=%b: got %b expected %b", v, b_out, e);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    a = 8'h11; b = 8'h22;
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      check_comb("reset_comb");
      step();
      check_regs("reset");
      n_checks++;
      if (out_q !== RST_VAL || out_vld !== 1'b0 || cnt !== '0) begin
        n_errors++;
        $display("FAIL reset_const: got q=%h vld=%b cnt=%0d expected q=%h vld=0 cnt=0",
                 out_q, out_vld, cnt, RST_VAL);
      end
    end
    sel = 1'b0; #1;
    check_comb("reset_comb_sel0");
  endtask

  task automatic test_capture();
    rst_n = 1'b1; en = 1'b1; a = 8'h5A; b = 8'hA5; sel = 1'b0;
    step();
    check_regs("capture_a");
    n_checks++;
    if (out_q !== 8'h5A || out_vld !== 1'b1) begin
      n_errors++;
      $display("FAIL capture_a: got q=%h vld=%b expected q=5a vld=1", out_q, out_vld);
    end
    // SEL change and EN on the same edge: capture new-SEL result and count.
    sel = 1'b1;
    step();
    check_regs("capture_b");
    n_checks++;
    if (out_q !== 8'hA5 || cnt !== 2'd1) begin
      n_errors++;
      $display("FAIL capture_b: got q=%h cnt=%0d expected q=a5 cnt=1", out_q, cnt);
    end
    en = 1'b0; a = 8'hFF; b = 8'h00;
    step();
    check_regs("hold");
    n_checks++;
    if (out_q !== 8'hA5 || out_vld !== 1'b0) begin
      n_errors++;
      $display("FAIL hold: got q=%h vld=%b expected q=a5 vld=0", out_q, out_vld);
    end
  endtask

  task automatic test_saturation();
    logic [CW-1:0] exp [5];
    exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst_n = 1'b0; en = 1'b0; sel = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sel = ~sel;
      step();
      check_regs("sat");
      n_checks++;
      if (cnt !== exp[i]) begin
        n_errors++;
        $display("FAIL sat[%0d]: got %0d expected %0d", i, cnt, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    rst_n = 1'b0; en = 1'b1; sel = 1'b0;
    step();
    rst_n = 1'b1; a = 8'h77; b = 8'h88;
    sel = 1'b1; step();
    sel = 1'b0; step();
    check_regs("mid_pre");
    rst_n = 1'b0; en = 1'b1; sel = 1'b1;
    step();
    check_regs("mid_reset");
    n_checks++;
    if (out_q !== RST_VAL || cnt !== '0 || out_vld !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset: got q=%h cnt=%0d vld=%b expected q=%h cnt=0 vld=0",
               out_q, cnt, out_vld, RST_VAL);
    end
    check_comb("mid_reset_comb");
    rst_n = 1'b1;
  endtask

  // Scoreboard: every capture's expected value is queued and popped when
  // the qualifier shows up.
  task automatic test_random();
    logic [W-1:0] e;
    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 15) != 0);
      en    = $urandom_range(0, 1);
      sel   = $urandom_range(0, 1);
      a     = W'($urandom);
      b     = W'($urandom);
      #1;
      check_comb("rand_comb");
      step();
      check_regs("rand");
      if (out_vld === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL rand_sb: got q=%h with no capture expected", out_q);
        end else begin
          e = exp_q.pop_front();
          if (out_q !== e) begin
            n_errors++;
            $display("FAIL rand_sb: got %h expected %h", out_q, e);
          end
        end
      end
    end
  endtask

  initial begin
    b_rst_n = 1'b0; b_en = 1'b0; b_a = 1'b0; b_b = 1'b0; b_sel = 1'b0;
    rst_n = 1'b0; en = 1'b0; sel = 1'b0; a = '0; b = '0;
    m_q = RST_VAL; m_vld = 1'b0; m_cnt = 0; m_prev = 1'b0;
    test_comb_sweep();
    test_comb_exhaustive();
    test_reset();
    test_capture();
    test_saturation();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
